// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the MMU data-port arbiter
//
// Purpose: FSM state encoding and timeout counter width used by
// mem_port_arbiter and its picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    // Width of the WAIT-cycle counter; TIMEOUT must fit in it (1..255).
    localparam int CNT_W = 8;

endpackage

// File: rtl/arb_rr_picker.sv
// rtl/arb_rr_picker.sv - combinational one-hot requester pick
//
// Purpose: chooses one requester from req, searching upward from ptr and
// wrapping (round-robin), or from index 0 when FIXED_PRIO != 0.
// Ports:
//   req      in   NUM_REQ   request vector
//   ptr      in   PTR_W     round-robin search start
//   pick_oh  out  NUM_REQ   one-hot winner, 0 when no request
//   pick_idx out  PTR_W     binary index of the winner (0 when none)
module arb_rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int FIXED_PRIO = 0,
    parameter int PTR_W      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick_oh,
    output logic [PTR_W-1:0]   pick_idx
);

    logic [PTR_W-1:0] start;
    logic             found;
    int               cand;

    always_comb begin
        start    = (FIXED_PRIO != 0) ? '0 : ptr;
        pick_oh  = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Candidate index walks start, start+1, ... modulo NUM_REQ.
            cand = int'(start) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[PTR_W'(cand)]) begin
                found                 = 1'b1;
                pick_oh[PTR_W'(cand)] = 1'b1;
                pick_idx              = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises NUM_REQ masters onto the MMU data port
//
// Purpose: grants one requester at a time, issues a single-cycle mem_ren or
// mem_wen strobe, waits for mem_stall to drop (or a timeout), then pulses
// req_done to the owner with read data / error.
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   req_valid/wen/addr/wdata/be    packed per-requester request, req 0 in LSBs
//   req_done, req_err, rsp_rdata   completion pulse, timeout flag, read data
//   grant                          one-hot current owner, 0 when idle
//   mem_ren/wen/addr/wdata/be      MMU access, held stable through WAIT
//   mem_rdata, mem_stall           MMU read data and busy indication
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 14,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_wen,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    input  logic [NUM_REQ*4-1:0]    req_be,
    output logic [NUM_REQ-1:0]      req_done,
    output logic                    req_err,
    output logic [31:0]             rsp_rdata,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    mem_ren,
    output logic                    mem_wen,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [3:0]              mem_be,
    input  logic [31:0]             mem_rdata,
    input  logic                    mem_stall
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    // Unpacked views of the packed request buses.
    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [31:0]       wdata_arr [NUM_REQ];
    logic [3:0]        be_arr    [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*32 +: 32];
        assign be_arr[g]    = req_be[g*4 +: 4];
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wen_q, wen_d;
    logic               mem_ren_q, mem_ren_d;
    logic               mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic [NUM_REQ-1:0] req_done_q, req_done_d;
    logic               req_err_q, req_err_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [PTR_W-1:0]   pick_idx;
    logic [CNT_W-1:0]   cnt_inc;

    arb_rr_picker #(
        .NUM_REQ    (NUM_REQ),
        .FIXED_PRIO (FIXED_PRIO),
        .PTR_W      (PTR_W)
    ) u_picker (
        .req      (req_valid),
        .ptr      (ptr_q),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        wen_d       = wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        rsp_rdata_d = rsp_rdata_q;
        // Strobes, done and err are single-cycle: default low.
        mem_ren_d   = 1'b0;
        mem_wen_d   = 1'b0;
        req_done_d  = '0;
        req_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_d     = pick_oh;
                    wen_d       = req_wen[pick_idx];
                    mem_addr_d  = addr_arr[pick_idx];
                    mem_wdata_d = wdata_arr[pick_idx];
                    mem_be_d    = be_arr[pick_idx];
                    mem_ren_d   = ~req_wen[pick_idx];
                    mem_wen_d   = req_wen[pick_idx];
                    cnt_d       = '0;
                    if (FIXED_PRIO == 0) begin
                        ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mem_stall) begin
                    if (!wen_q) begin
                        rsp_rdata_d = mem_rdata;
                    end
                    req_done_d = grant_q;
                    state_d    = ST_DONE;
                end else if (cnt_inc == TIMEOUT_C) begin
                    // Hung access: abandon it and report the error with done.
                    req_done_d = grant_q;
                    req_err_d  = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            wen_q       <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            req_done_q  <= '0;
            req_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            wen_q       <= wen_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            req_done_q  <= req_done_d;
            req_err_q   <= req_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign grant     = grant_q;
    assign mem_ren   = mem_ren_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign req_done  = req_done_q;
    assign req_err   = req_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid, req_wen;
    logic [27:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic [31:0] mem_rdata;
    logic        stall_a, stall_t;

    logic [1:0]  done_a, grant_a, done_f, grant_f, done_t, grant_t;
    logic        err_a, err_f, err_t;
    logic [31:0] rdata_a, rdata_f, rdata_t;
    logic        ren_a, wen_a, ren_f, wen_f, ren_t, wen_t;
    logic [13:0] maddr_a, maddr_f, maddr_t;
    logic [31:0] mwdata_a, mwdata_f, mwdata_t;
    logic [3:0]  mbe_a, mbe_f, mbe_t;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(14), .FIXED_PRIO(0), .TIMEOUT(255)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_done(done_a), .req_err(err_a), .rsp_rdata(rdata_a), .grant(grant_a),
        .mem_ren(ren_a), .mem_wen(wen_a), .mem_addr(maddr_a), .mem_wdata(mwdata_a),
        .mem_be(mbe_a), .mem_rdata(mem_rdata), .mem_stall(stall_a));

    mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(14), .FIXED_PRIO(1), .TIMEOUT(255)) dut_fp (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_done(done_f), .req_err(err_f), .rsp_rdata(rdata_f), .grant(grant_f),
        .mem_ren(ren_f), .mem_wen(wen_f), .mem_addr(maddr_f), .mem_wdata(mwdata_f),
        .mem_be(mbe_f), .mem_rdata(mem_rdata), .mem_stall(stall_a));

    mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(14), .FIXED_PRIO(0), .TIMEOUT(4)) dut_to (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_done(done_t), .req_err(err_t), .rsp_rdata(rdata_t), .grant(grant_t),
        .mem_ren(ren_t), .mem_wen(wen_t), .mem_addr(maddr_t), .mem_wdata(mwdata_t),
        .mem_be(mbe_t), .mem_rdata(mem_rdata), .mem_stall(stall_t));

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (grant_a !== 2'b00) begin tests_failed++; $display("FAIL reset_grant: got %b expected 00", grant_a); end
        tests_run++;
        if ({ren_a, wen_a} !== 2'b00) begin tests_failed++; $display("FAIL reset_strobes: got %b expected 00", {ren_a, wen_a}); end
        tests_run++;
        if ({done_a, err_a} !== 3'b000) begin tests_failed++; $display("FAIL reset_done_err: got %b expected 000", {done_a, err_a}); end
        tests_run++;
        if (rdata_a !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 0", rdata_a); end
        tests_run++;
        if (maddr_a !== 14'h0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0", maddr_a); end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_read();
        int done_cyc;
        int ren_cnt;
        logic [1:0] done_val;
        logic err_val;
        done_cyc = -1; ren_cnt = 0; done_val = 2'b00; err_val = 1'b1;
        req_addr[13:0] = 14'h010; req_wen = 2'b00; mem_rdata = 32'hDEADBEEF;
        stall_a = 1'b0; req_valid = 2'b01;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ren_a) ren_cnt++;
            if (c == 1) begin
                tests_run++;
                if (grant_a !== 2'b01) begin tests_failed++; $display("FAIL read_grant: got %b expected 01", grant_a); end
                tests_run++;
                if (maddr_a !== 14'h010) begin tests_failed++; $display("FAIL read_addr: got %h expected 010", maddr_a); end
            end
            if (done_a !== 2'b00 && done_cyc < 0) begin
                done_cyc = c; done_val = done_a; err_val = err_a; req_valid = 2'b00;
            end
        end
        req_valid = 2'b00;
        tests_run++;
        if (done_cyc != 3) begin tests_failed++; $display("FAIL read_latency: got %0d expected 3", done_cyc); end
        tests_run++;
        if (done_val !== 2'b01) begin tests_failed++; $display("FAIL read_done: got %b expected 01", done_val); end
        tests_run++;
        if (err_val !== 1'b0) begin tests_failed++; $display("FAIL read_err: got %b expected 0", err_val); end
        tests_run++;
        if (ren_cnt != 1) begin tests_failed++; $display("FAIL read_ren_pulses: got %0d expected 1", ren_cnt); end
        tests_run++;
        if (rdata_a !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL read_rdata: got %h expected deadbeef", rdata_a); end
    endtask

    task automatic test_stalled_write();
        int done_cyc;
        int wen_cnt;
        int ren_cnt;
        int unstable;
        logic [1:0] done_val;
        logic err_val;
        done_cyc = -1; wen_cnt = 0; ren_cnt = 0; unstable = 0; done_val = 2'b00; err_val = 1'b1;
        req_addr[27:14] = 14'h2A5; req_wdata[63:32] = 32'h12345678; req_be[7:4] = 4'b0011;
        req_wen = 2'b10; mem_rdata = 32'h0BADF00D; stall_a = 1'b1; req_valid = 2'b10;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (wen_a) wen_cnt++;
            if (ren_a) ren_cnt++;
            if (done_cyc < 0 && (maddr_a !== 14'h2A5 || mwdata_a !== 32'h12345678 || mbe_a !== 4'b0011))
                unstable++;
            if (c == 1) begin
                tests_run++;
                if (grant_a !== 2'b10) begin tests_failed++; $display("FAIL write_grant: got %b expected 10", grant_a); end
            end
            if (done_a !== 2'b00 && done_cyc < 0) begin
                done_cyc = c; done_val = done_a; err_val = err_a; req_valid = 2'b00;
            end
            if (c == 7) stall_a = 1'b0;
        end
        req_valid = 2'b00;
        tests_run++;
        if (wen_cnt != 1) begin tests_failed++; $display("FAIL write_wen_pulses: got %0d expected 1", wen_cnt); end
        tests_run++;
        if (ren_cnt != 0) begin tests_failed++; $display("FAIL write_ren_pulses: got %0d expected 0", ren_cnt); end
        tests_run++;
        if (unstable != 0) begin tests_failed++; $display("FAIL write_mem_stable: got %0d unstable cycles expected 0", unstable); end
        tests_run++;
        if (done_cyc != 8) begin tests_failed++; $display("FAIL write_latency: got %0d expected 8", done_cyc); end
        tests_run++;
        if (done_val !== 2'b10) begin tests_failed++; $display("FAIL write_done: got %b expected 10", done_val); end
        tests_run++;
        if (err_val !== 1'b0) begin tests_failed++; $display("FAIL write_err: got %b expected 0", err_val); end
        tests_run++;
        if (rdata_a !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL write_rdata_held: got %h expected deadbeef", rdata_a); end
    endtask

    task automatic test_round_robin();
        logic [1:0] ga [4];
        logic [1:0] gf [4];
        logic [1:0] prev_a, prev_f;
        logic [1:0] exp_a;
        int na, nf;
        na = 0; nf = 0; prev_a = 2'b00; prev_f = 2'b00;
        for (int i = 0; i < 4; i++) begin ga[i] = 2'b00; gf[i] = 2'b00; end
        req_addr = {14'h100, 14'h200}; req_wen = 2'b00; stall_a = 1'b0; req_valid = 2'b11;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (grant_a !== 2'b00 && prev_a === 2'b00 && na < 4) begin ga[na] = grant_a; na++; end
            if (grant_f !== 2'b00 && prev_f === 2'b00 && nf < 4) begin gf[nf] = grant_f; nf++; end
            prev_a = grant_a; prev_f = grant_f;
            if (na >= 4 && nf >= 4) break;
        end
        req_valid = 2'b00;
        repeat (8) @(negedge clk);
        tests_run++;
        if (na != 4 || nf != 4) begin tests_failed++; $display("FAIL rr_grant_count: got %0d/%0d expected 4/4", na, nf); end
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0) ? 2'b01 : 2'b10;
            tests_run++;
            if (ga[i] !== exp_a) begin tests_failed++; $display("FAIL rr_order[%0d]: got %b expected %b", i, ga[i], exp_a); end
            tests_run++;
            if (gf[i] !== 2'b01) begin tests_failed++; $display("FAIL fixed_order[%0d]: got %b expected 01", i, gf[i]); end
        end
    endtask

    task automatic test_withdrawn();
        int done_cyc;
        logic [1:0] done_val;
        done_cyc = -1; done_val = 2'b00;
        req_addr[13:0] = 14'h033; req_wen = 2'b00; mem_rdata = 32'hCAFEF00D;
        stall_a = 1'b1; req_valid = 2'b01;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done_a !== 2'b00 && done_cyc < 0) begin done_cyc = c; done_val = done_a; end
            if (c == 2) req_valid = 2'b00;
            if (c == 3) stall_a = 1'b0;
        end
        tests_run++;
        if (done_cyc != 4) begin tests_failed++; $display("FAIL withdraw_latency: got %0d expected 4", done_cyc); end
        tests_run++;
        if (done_val !== 2'b01) begin tests_failed++; $display("FAIL withdraw_done: got %b expected 01", done_val); end
        tests_run++;
        if (rdata_a !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL withdraw_rdata: got %h expected cafef00d", rdata_a); end
        tests_run++;
        if (grant_a !== 2'b00) begin tests_failed++; $display("FAIL withdraw_idle: got %b expected 00", grant_a); end
    endtask

    task automatic test_reset_mid_wait();
        int spurious;
        spurious = 0;
        req_addr[27:14] = 14'h044; req_wen = 2'b00; mem_rdata = 32'h11111111;
        stall_a = 1'b1; req_valid = 2'b10;
        repeat (3) @(negedge clk);
        tests_run++;
        if (grant_a !== 2'b10) begin tests_failed++; $display("FAIL rst_pre_grant: got %b expected 10", grant_a); end
        #2 resetn = 1'b0;
        #1;
        tests_run++;
        if (grant_a !== 2'b00) begin tests_failed++; $display("FAIL rst_async_grant: got %b expected 00", grant_a); end
        tests_run++;
        if ({ren_a, wen_a, done_a} !== 4'b0000) begin tests_failed++; $display("FAIL rst_async_outputs: got %b expected 0000", {ren_a, wen_a, done_a}); end
        tests_run++;
        if (rdata_a !== 32'h0) begin tests_failed++; $display("FAIL rst_async_rdata: got %h expected 0", rdata_a); end
        req_valid = 2'b00; stall_a = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done_a !== 2'b00 || grant_a !== 2'b00) spurious++;
        end
        tests_run++;
        if (spurious != 0) begin tests_failed++; $display("FAIL rst_no_done_after: got %0d active cycles expected 0", spurious); end
    endtask

    task automatic test_timeout();
        int done_cyc, done2_cyc;
        logic [1:0] done_val, done2_val;
        logic err_val, err_next, err2;
        done_cyc = -1; done2_cyc = -1; done_val = 2'b00; done2_val = 2'b00;
        err_val = 1'b0; err_next = 1'b1; err2 = 1'b1;
        req_addr[13:0] = 14'h055; req_wen = 2'b00; stall_a = 1'b0; stall_t = 1'b1;
        req_valid = 2'b01;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (done_cyc > 0 && c == done_cyc + 1) err_next = err_t;
            if (done_cyc > 0 && done2_cyc < 0 && c > done_cyc && done_t !== 2'b00) begin
                done2_cyc = c; done2_val = done_t; err2 = err_t; req_valid = 2'b00;
            end
            if (done_cyc < 0 && done_t !== 2'b00) begin
                done_cyc = c; done_val = done_t; err_val = err_t;
                req_wdata[63:32] = 32'hA5A5A5A5; req_be[7:4] = 4'b1111;
                req_wen = 2'b10; req_valid = 2'b10; stall_t = 1'b0;
            end
        end
        req_valid = 2'b00;
        tests_run++;
        if (done_cyc != 6) begin tests_failed++; $display("FAIL timeout_latency: got %0d expected 6", done_cyc); end
        tests_run++;
        if (done_val !== 2'b01) begin tests_failed++; $display("FAIL timeout_done: got %b expected 01", done_val); end
        tests_run++;
        if (err_val !== 1'b1) begin tests_failed++; $display("FAIL timeout_err: got %b expected 1", err_val); end
        tests_run++;
        if (err_next !== 1'b0) begin tests_failed++; $display("FAIL timeout_err_clear: got %b expected 0", err_next); end
        tests_run++;
        if (done2_cyc != 10) begin tests_failed++; $display("FAIL timeout_next_latency: got %0d expected 10", done2_cyc); end
        tests_run++;
        if (done2_val !== 2'b10) begin tests_failed++; $display("FAIL timeout_next_done: got %b expected 10", done2_val); end
        tests_run++;
        if (err2 !== 1'b0) begin tests_failed++; $display("FAIL timeout_next_err: got %b expected 0", err2); end
    endtask

    initial begin
        resetn = 1'b0; req_valid = 2'b00; req_wen = 2'b00; req_addr = '0;
        req_wdata = '0; req_be = '0; mem_rdata = '0; stall_a = 1'b0; stall_t = 1'b0;
        test_reset();
        test_single_read();
        test_stalled_write();
        test_round_robin();
        test_withdrawn();
        test_reset_mid_wait();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
